dot_accumulator: RTL and testbench
==================================

DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

Interface
REQ-001 SHALL have parameter DATAW, default 24, signed input width per lane (the output width of the upstream reduction stage).
REQ-002 SHALL have parameter LANES, default 1, number of independent lanes.
REQ-003 SHALL have parameter ACCW, default 32, signed accumulator and output width; ACCW >= DATAW.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, number of result entries buffered (power of 2, >= 2).
REQ-005 SHALL have parameter AF_MARGIN, default 2, free-entry margin for o_almost_full.
REQ-006 SHALL use clock clk, input, 1 bit, with all state on its rising edge.
REQ-007 SHALL use reset rst, input, 1 bit: synchronous, active-high.
REQ-008 SHALL have i_data, input, [LANES] x DATAW signed, partial sums from the reduction stage.
REQ-009 SHALL have i_valid, input, 1 bit, i_data valid this cycle (no backpressure is possible upstream).
REQ-010 SHALL have i_last, input, 1 bit, qualified by i_valid, marking the final chunk of a dot product.
REQ-011 SHALL have o_data, output, [LANES] x ACCW signed, head-of-buffer result.
REQ-012 SHALL have o_valid, output, 1 bit, buffer non-empty.
REQ-013 SHALL have i_ready, input, 1 bit, consumer accepts o_data when o_valid && i_ready.
REQ-014 SHALL have o_almost_full, output, 1 bit, set when occupancy >= FIFO_DEPTH-AF_MARGIN.
REQ-015 SHALL have o_err, output, 1 bit, sticky flag for dropped result or saturation.

Function
REQ-016 SHALL sign-extend i_data to ACCW before any addition.
REQ-017 SHALL, on i_valid && !i_last, set acc[l] <= sat(acc[l] + i_data[l]) for every lane, with no buffer push.
REQ-018 SHALL, on i_valid && i_last, push sat(acc[l] + i_data[l]) for all lanes as one buffer entry and clear acc to 0 in the same edge.
REQ-019 SHALL saturate sat() to [-2^(ACCW-1), 2^(ACCW-1)-1]; any saturation event SHALL set o_err.
REQ-020 SHALL have latency 1: a last-chunk push at edge t gives o_valid=1 and the new o_data after edge t if the buffer was empty.
REQ-021 SHALL pop on o_valid && i_ready; o_data SHALL hold stable while o_valid && !i_ready.
REQ-022 SHALL complete both operations when push and pop occur in the same cycle, with occupancy unchanged, including when full.
REQ-023 SHALL drop a push while full without a pop: buffer contents unchanged, acc still cleared, o_err set.
REQ-024 SHALL ignore i_ready while empty, with no state change.
REQ-025 SHALL ignore i_last while i_valid=0.
REQ-026 SHALL wrap read/write pointers modulo FIFO_DEPTH, using an occupancy counter 0..FIFO_DEPTH for full/empty.
REQ-027 SHALL keep o_err set until rst.
REQ-028 SHALL process all lanes in lockstep with shared valid/occupancy state.

Reset
REQ-029 SHALL, on rst, clear acc to 0, pointers and occupancy to 0, o_valid to 0, o_almost_full to 0 and o_err to 0.
REQ-030 SHALL discard a partial accumulation and all buffered results when rst is asserted mid-operation; input on the rst cycle SHALL be ignored.
REQ-031 SHALL leave o_data contents don't-care while o_valid=0.

Structure
REQ-032 SHALL take the saturation bounds function and default widths (DATAW, ACCW) from the shared npu_pkg package.
REQ-033 SHALL instantiate exactly one sub-module result_fifo (parameterised width LANES*ACCW, depth, almost-full margin); accumulation and saturation SHALL stay in dot_accumulator.

Verification
REQ-034 SHALL cover: LANES=2, chunks {3,-1},{4,5},{-2,7} with last on the third, i_ready=1 -> one result {5,11}, o_valid one cycle after the last input.
REQ-035 SHALL cover: 5 single-chunk results with i_ready=0, FIFO_DEPTH=4 -> o_almost_full after 2nd push, 5th dropped, o_err=1, then drain yields the first 4 in order.
REQ-036 SHALL cover: ACCW=8, chunks 100,100 with last -> output 127 and o_err=1; chunks -100,-100 -> output -128.
REQ-037 SHALL cover: full buffer with push and pop in the same cycle -> occupancy stays 4, popped is the oldest, pushed lands at the tail.
REQ-038 SHALL cover: rst after 2 non-last chunks, then chunk 9 with last -> output 9 (earlier partial discarded), o_valid=0 during and after rst until the push.
REQ-039 SHALL cover: back-to-back i_valid && i_last every cycle with i_ready=1 -> one result per cycle, no drops, o_err=0.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: default datapath widths and signed saturation bounds.
package npu_pkg;

    localparam int DEF_DATAW = 24;
    localparam int DEF_ACCW  = 32;

    // Bounds are returned as longint so any width up to 63 bits can be compared without truncation.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/dot_accumulator_result_fifo.sv
// Result buffer for dot_accumulator: power-of-2 ring with an occupancy counter.
module result_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_empty,
    output logic             full,
    output logic             almost_full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign not_empty   = (count_q != '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almost_full = (count_q >= CNT_W'(DEPTH - AF_MARGIN));
    assign do_pop      = pop && not_empty;
    // A pop frees the head slot this edge, so a push into a full buffer still lands.
    assign do_push     = push && (!full || do_pop);
    assign rd_data     = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only visible once the counter says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dot_accumulator.sv
// Per-lane saturating accumulation of reduction-stage partial sums; finished dot products are buffered.
module dot_accumulator
    import npu_pkg::*;
#(
    parameter int DATAW      = DEF_DATAW,
    parameter int LANES      = 1,
    parameter int ACCW       = DEF_ACCW,
    parameter int FIFO_DEPTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES-1:0][DATAW-1:0] i_data,
    input  logic                        i_valid,
    input  logic                        i_last,
    output logic [LANES-1:0][ACCW-1:0]  o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_almost_full,
    output logic                        o_err
);

    localparam longint ACC_MAX = sat_max(ACCW);
    localparam longint ACC_MIN = sat_min(ACCW);

    logic [LANES-1:0][ACCW-1:0] acc_q;
    logic [LANES-1:0][ACCW-1:0] sat_sum;
    logic signed [ACCW:0]       sum_w [LANES];
    logic                       sat_any;
    logic                       err_q;
    logic                       push;
    logic                       fifo_full;
    logic                       drop;

    // One extra bit of headroom makes the raw sum exact before clamping.
    always_comb begin
        sat_any = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            sum_w[l] = (ACCW+1)'($signed(acc_q[l])) + (ACCW+1)'($signed(ACCW'($signed(i_data[l]))));
            if (longint'(sum_w[l]) > ACC_MAX) begin
                sat_sum[l] = ACC_MAX[ACCW-1:0];
                sat_any    = 1'b1;
            end else if (longint'(sum_w[l]) < ACC_MIN) begin
                sat_sum[l] = ACC_MIN[ACCW-1:0];
                sat_any    = 1'b1;
            end else begin
                sat_sum[l] = sum_w[l][ACCW-1:0];
            end
        end
    end

    assign push = i_valid && i_last;
    // A full buffer always presents o_valid, so i_ready alone decides whether a slot frees up.
    assign drop = push && fifo_full && !i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (i_valid) acc_q <= i_last ? '0 : sat_sum;
            if ((i_valid && sat_any) || drop) err_q <= 1'b1;
        end
    end

    assign o_err = err_q;

    result_fifo #(
        .WIDTH    (LANES * ACCW),
        .DEPTH    (FIFO_DEPTH),
        .AF_MARGIN(AF_MARGIN)
    ) u_result_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (sat_sum),
        .pop        (i_ready),
        .rd_data    (o_data),
        .not_empty  (o_valid),
        .full       (fifo_full),
        .almost_full(o_almost_full)
    );

endmodule

// File: tb/tb_dot_accumulator.sv
// Self-checking bench for dot_accumulator (2 lanes, 8-bit data and accumulator, depth 4) against a queue model.
module tb_dot_accumulator;

    localparam int LANES = 2;
    localparam int DATAW = 8;
    localparam int ACCW  = 8;
    localparam int DEPTH = 4;
    localparam int AMAX  = 127;
    localparam int AMIN  = -128;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [LANES-1:0][DATAW-1:0] i_data = '0;
    logic                        i_valid = 1'b0;
    logic                        i_last = 1'b0;
    logic [LANES-1:0][ACCW-1:0]  o_data;
    logic                        o_valid;
    logic                        i_ready = 1'b0;
    logic                        o_almost_full;
    logic                        o_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int l0;
        int l1;
    } res_t;

    int   m_acc [LANES];
    res_t m_q[$];
    bit   m_err;

    dot_accumulator #(
        .DATAW     (DATAW),
        .LANES     (LANES),
        .ACCW      (ACCW),
        .FIFO_DEPTH(DEPTH),
        .AF_MARGIN (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_last       (i_last),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_almost_full(o_almost_full),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint lane(input int i);
        return longint'($signed(o_data[i]));
    endfunction

    function automatic int clamp(input int x, output bit hit);
        hit = 1'b0;
        if (x > AMAX) begin
            hit = 1'b1;
            return AMAX;
        end
        if (x < AMIN) begin
            hit = 1'b1;
            return AMIN;
        end
        return x;
    endfunction

    // Reference behaviour of one clock edge, written from the accumulate/buffer rules.
    task automatic model_edge(input bit v, input bit l, input int d0, input int d1, input bit rdy, input bit r);
        bit   pop;
        bit   hit0;
        bit   hit1;
        bit   do_push;
        res_t res;
        if (r) begin
            m_acc[0] = 0;
            m_acc[1] = 0;
            m_q.delete();
            m_err = 1'b0;
            return;
        end
        pop     = (m_q.size() != 0) && rdy;
        do_push = 1'b0;
        if (v) begin
            res.l0 = clamp(m_acc[0] + d0, hit0);
            res.l1 = clamp(m_acc[1] + d1, hit1);
            if (hit0 || hit1) m_err = 1'b1;
            if (!l) begin
                m_acc[0] = res.l0;
                m_acc[1] = res.l1;
            end else begin
                m_acc[0] = 0;
                m_acc[1] = 0;
                if (m_q.size() < DEPTH || pop) do_push = 1'b1;
                else                           m_err = 1'b1;
            end
        end
        if (pop)     void'(m_q.pop_front());
        if (do_push) m_q.push_back(res);
    endtask

    task automatic compare_model();
        check("valid", o_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("data_l0", lane(0), m_q[0].l0);
            check("data_l1", lane(1), m_q[0].l1);
        end
        check("afull", o_almost_full, m_q.size() >= 2);
        check("err", o_err, m_err);
    endtask

    task automatic step(input bit v, input bit l, input int d0, input int d1, input bit rdy, input bit r = 1'b0);
        rst       = r;
        i_valid   = v;
        i_last    = l;
        i_data[0] = d0[DATAW-1:0];
        i_data[1] = d1[DATAW-1:0];
        i_ready   = rdy;
        @(posedge clk);
        model_edge(v, l, d0, d1, rdy, r);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 77, -77, 1'b1, 1'b1);
    endtask

    initial begin
        int exp_q [DEPTH];

        // Reset state
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        check("rst_valid", o_valid, 0);
        check("rst_afull", o_almost_full, 0);
        check("rst_err", o_err, 0);

        // Three-chunk dot product on two lanes
        step(1'b1, 1'b0, 3, -1, 1'b1);
        step(1'b1, 1'b0, 4, 5, 1'b1);
        check("acc_no_push", o_valid, 0);
        step(1'b1, 1'b1, -2, 7, 1'b1);
        check("dot_valid", o_valid, 1);
        check("dot_l0", lane(0), 5);
        check("dot_l1", lane(1), 11);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        check("dot_popped", o_valid, 0);

        // Overflow the buffer with the consumer stalled, then drain
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 10 + k, 20 + k, 1'b0);
            if (k == 0) check("af_after1", o_almost_full, 0);
            if (k == 1) check("af_after2", o_almost_full, 1);
            if (k == 3) check("err_before_drop", o_err, 0);
        end
        check("drop_err", o_err, 1);
        for (int k = 0; k < DEPTH; k++) begin
            check("drain_order", lane(0), 10 + k);
            step(1'b0, 1'b1, 0, 0, 1'b1);
        end
        check("drain_empty", o_valid, 0);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        check("err_sticky", o_err, 1);
        do_reset();
        check("err_cleared", o_err, 0);

        // Saturation at both bounds
        step(1'b1, 1'b0, 100, 0, 1'b1);
        step(1'b1, 1'b1, 100, 0, 1'b1);
        check("sat_hi", lane(0), 127);
        check("sat_err", o_err, 1);
        step(1'b1, 1'b0, -100, 0, 1'b1);
        step(1'b1, 1'b1, -100, 0, 1'b1);
        check("sat_lo", lane(0), -128);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        do_reset();

        // Simultaneous push and pop while full
        for (int k = 1; k <= DEPTH; k++) step(1'b1, 1'b1, k, -k, 1'b0);
        check("full_head", lane(0), 1);
        step(1'b1, 1'b1, 50, 60, 1'b1);
        check("pp_head", lane(0), 2);
        check("pp_afull", o_almost_full, 1);
        check("pp_noerr", o_err, 0);
        exp_q = '{2, 3, 4, 50};
        for (int k = 0; k < DEPTH; k++) begin
            check("pp_drain", lane(0), exp_q[k]);
            step(1'b0, 1'b0, 0, 0, 1'b1);
        end
        check("pp_empty", o_valid, 0);

        // Reset mid-accumulation discards the partial sum
        step(1'b1, 1'b0, 30, 30, 1'b1);
        step(1'b1, 1'b0, 30, 30, 1'b1);
        step(1'b1, 1'b1, 99, 99, 1'b1, 1'b1);
        check("rst_mid_valid", o_valid, 0);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        check("post_rst_valid", o_valid, 0);
        step(1'b1, 1'b1, 9, 9, 1'b1);
        check("post_rst_l0", lane(0), 9);
        check("post_rst_l1", lane(1), 9);
        step(1'b0, 1'b0, 0, 0, 1'b1);

        // Back-to-back single-chunk products with a ready consumer
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, k * 3, -k, 1'b1);
            check("b2b_valid", o_valid, 1);
            check("b2b_l0", lane(0), k * 3);
            check("b2b_l1", lane(1), -k);
        end
        check("b2b_err", o_err, 0);
        step(1'b0, 1'b0, 0, 0, 1'b1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit v;
            bit l;
            bit rdy;
            bit r;
            int d0;
            int d1;
            v   = ($urandom_range(0, 3) != 0);
            l   = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            r   = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 9) == 0) begin
                d0 = int'($urandom_range(0, 255)) - 128;
                d1 = int'($urandom_range(0, 255)) - 128;
            end else begin
                d0 = int'($urandom_range(0, 40)) - 20;
                d1 = int'($urandom_range(0, 40)) - 20;
            end
            step(v, l, d0, d1, rdy, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
